// File: rtl/pipeline_stage_skid_if.sv
//==============================================================================
// Module      : pipeline_stage_skid_if
// Description : Upstream/downstream valid-ready bus of the elastic stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface pipeline_stage_skid_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [CTRL_WIDTH-1:0] in_ctrl;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic [DATA_WIDTH-1:0] out_data;

    // master: the environment around the stage (producer and consumer)
    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

    // slave: the pipeline stage itself
    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_stage_skid.sv
//==============================================================================
// Module      : pipeline_stage_skid
// Description : Elastic pipeline register with 2-entry skid, flush and a
//               saturating back-pressure counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipeline_stage_skid #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 flush,
    pipeline_stage_skid_if.slave      bus,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [CTRL_WIDTH-1:0] r_m_ctrl;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [CTRL_WIDTH-1:0] r_s_ctrl;
    logic [DATA_WIDTH-1:0] r_s_data;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;

    logic   w_in_fire;
    logic   w_out_fire;
    state_t w_state_nxt;
    logic   w_load_m_in;
    logic   w_load_m_s;
    logic   w_load_s;

    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load_m_in = 1'b0;
        w_load_m_s  = 1'b0;
        w_load_s    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_ONE;
                    w_load_m_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_m_in = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_in_fire) begin
                    w_state_nxt = ST_FULL;
                    w_load_s    = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt = ST_ONE;
                    w_load_m_s  = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // Flush kills everything, including a same-cycle accepted input.
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_load_m_in = 1'b0;
            w_load_m_s  = 1'b0;
            w_load_s    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_m_ctrl    <= '0;
            r_m_data    <= '0;
            r_s_ctrl    <= '0;
            r_s_data    <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            if (w_load_m_in) begin
                r_m_ctrl <= bus.in_ctrl;
                r_m_data <= bus.in_data;
            end else if (w_load_m_s) begin
                r_m_ctrl <= r_s_ctrl;
                r_m_data <= r_s_data;
            end
            if (w_load_s) begin
                r_s_ctrl <= bus.in_ctrl;
                r_s_data <= bus.in_data;
            end
            if (r_out_valid && !bus.out_ready && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    // Bubbles must never carry live control bits downstream.
    assign bus.out_ctrl  = r_m_ctrl & {CTRL_WIDTH{r_out_valid}};
    assign bus.out_data  = r_m_data;
    assign stall_cnt     = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stage_skid.sv
//==============================================================================
// Module      : tb_pipeline_stage_skid
// Description : Directed and randomized bench for pipeline_stage_skid.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipeline_stage_skid;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NW = 4;
    localparam logic [NW-1:0] CNT_MAX = '1;

    logic clk;
    logic rst;
    logic flush;
    logic [NW-1:0] stall_cnt;

    pipeline_stage_skid_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

    pipeline_stage_skid #(
        .DATA_WIDTH(DW),
        .CTRL_WIDTH(CW),
        .CNT_WIDTH (NW)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus.slave),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of held transactions, capacity two.
    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;
    ent_t          q[$];
    logic [NW-1:0] m_cnt  = '0;
    logic          m_rdy  = 1'b0;
    logic [DW-1:0] m_last = '0;

    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt  = '0;
            m_rdy  = 1'b0;
            m_last = '0;
        end else begin
            if (q.size() > 0 && !bus.out_ready && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
                if (bus.in_valid && m_rdy) begin
                    e.c = bus.in_ctrl;
                    e.d = bus.in_data;
                    q.push_back(e);
                end
            end
            m_rdy = (q.size() < 2);
            if (q.size() > 0) m_last = q[0].d;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        bus.in_valid = v;
        bus.in_ctrl  = c;
        bus.in_data  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; bus.out_ready = 1'b1;
        drive(1'b0, '0, '0);
        tick(); tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 8'h00 || bus.out_data !== 32'h0 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ctrl=%h data=%h cnt=%0d required 0/00/0/0",
                     bus.out_valid, bus.out_ctrl, bus.out_data, stall_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, CW'(i + 1), DW'(32'h11 + i));
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(32'h11 + i) || bus.out_ctrl !== CW'(i + 1)) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b data=%h ctrl=%h required 1/%h/%h",
                         i, bus.out_valid, bus.out_data, bus.out_ctrl, 32'h11 + i, i + 1);
            end
        end
        drive(1'b0, '0, '0);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h14 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL stream_drain: valid=%b data=%h cnt=%0d required 0/14/0",
                     bus.out_valid, bus.out_data, stall_cnt);
        end
    endtask

    task automatic test_skid();
        bus.out_ready = 1'b1;
        drive(1'b1, 8'h0A, 32'hA0);
        tick();
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h0B, 32'hA1);
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_data !== 32'hA0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL skid_capture: in_ready=%b data=%h valid=%b required 0/a0/1",
                     bus.in_ready, bus.out_data, bus.out_valid);
        end
        drive(1'b1, 8'h0C, 32'hA2);
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_data !== 32'hA0) begin
            errors++;
            $display("FAIL skid_hold: in_ready=%b data=%h required 0/a0", bus.in_ready, bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_data !== 32'hA1 || bus.out_ctrl !== 8'h0B || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL skid_release1: data=%h ctrl=%h in_ready=%b required a1/0b/1",
                     bus.out_data, bus.out_ctrl, bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_data !== 32'hA2 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL skid_release2: data=%h valid=%b required a2/1", bus.out_data, bus.out_valid);
        end
        drive(1'b0, '0, '0);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || stall_cnt !== 4'd2) begin
            errors++;
            $display("FAIL skid_end: valid=%b cnt=%0d required 0/2", bus.out_valid, stall_cnt);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h10, 32'hB0);
        tick();
        drive(1'b1, 8'h11, 32'hB1);
        tick();
        flush = 1'b1;
        drive(1'b1, 8'h12, 32'hB2);
        tick();
        flush = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 8'h00 || bus.in_ready !== 1'b1 ||
            bus.out_data !== 32'hB0 || stall_cnt !== 4'd4) begin
            errors++;
            $display("FAIL flush_full: valid=%b ctrl=%h in_ready=%b data=%h cnt=%0d required 0/00/1/b0/4",
                     bus.out_valid, bus.out_ctrl, bus.in_ready, bus.out_data, stall_cnt);
        end
        drive(1'b0, '0, '0);
        bus.out_ready = 1'b1;
        tick(); tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data === 32'hB2) begin
            errors++;
            $display("FAIL flush_dropped: valid=%b data=%h required 0/not b2", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_bubble();
        bus.out_ready = 1'b1;
        drive(1'b1, 8'hFF, 32'hC3);
        tick();
        checks++;
        if (bus.out_ctrl !== 8'hFF) begin
            errors++;
            $display("FAIL bubble_pass: ctrl=%h required ff", bus.out_ctrl);
        end
        drive(1'b0, '0, '0);
        tick();
        checks++;
        if (bus.out_ctrl !== 8'h00 || bus.out_data !== 32'hC3 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bubble_mask: ctrl=%h data=%h valid=%b required 00/c3/0",
                     bus.out_ctrl, bus.out_data, bus.out_valid);
        end
    endtask

    task automatic test_saturation();
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h01, 32'hD0);
        tick();
        drive(1'b0, '0, '0);
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (stall_cnt !== 4'd15 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold: cnt=%0d valid=%b required 15/1", stall_cnt, bus.out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (stall_cnt !== 4'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_reset: cnt=%0d valid=%b required 0/0", stall_cnt, bus.out_valid);
        end
        tick();
    endtask

    task automatic test_random();
        logic          exp_v;
        logic [CW-1:0] exp_c;
        logic [DW-1:0] exp_d;
        logic          rdy_before;
        int            nerr_before;
        nerr_before = errors;
        for (int n = 0; n < 10000; n++) begin
            drive($urandom_range(0, 99) < 60, CW'($urandom), DW'($urandom));
            bus.out_ready = ($urandom_range(0, 99) < 55);
            flush         = ($urandom_range(0, 99) < 10);
            if (n % 97 == 0) begin
                rdy_before    = bus.in_ready;
                bus.out_ready = ~bus.out_ready;
                #1;
                checks++;
                if (bus.in_ready !== rdy_before) begin
                    errors++;
                    $display("FAIL rand_ready_comb @%0d: in_ready=%b required %b", n, bus.in_ready, rdy_before);
                end
                bus.out_ready = ~bus.out_ready;
            end
            tick();
            exp_v = (q.size() > 0);
            exp_c = exp_v ? q[0].c : '0;
            exp_d = exp_v ? q[0].d : m_last;
            checks++;
            if (bus.out_valid !== exp_v || bus.out_ctrl !== exp_c || bus.out_data !== exp_d ||
                bus.in_ready !== m_rdy || stall_cnt !== m_cnt) begin
                errors++;
                if (errors - nerr_before <= 10)
                    $display("FAIL rand_cycle %0d: v=%b c=%h d=%h rdy=%b cnt=%0d required v=%b c=%h d=%h rdy=%b cnt=%0d",
                             n, bus.out_valid, bus.out_ctrl, bus.out_data, bus.in_ready, stall_cnt,
                             exp_v, exp_c, exp_d, m_rdy, m_cnt);
            end
        end
        flush = 1'b0;
        drive(1'b0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_bubble();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
